debounce_scheduler: RTL and testbench
=====================================

Name: debounce_scheduler

Overview:
Time-shared debounce controller for up to NUM_SWITCHES raw switch inputs, serviced by one settle counter instead of one counter per switch. A round-robin scheduler grants the counter to one switch whose synchronized level differs from its committed state. The granted switch commits only after holding the new level for DEBOUNCE_LIMIT consecutive clocks. Sits between board switch pins and the LED, 7-segment and counter logic; emits stable levels plus one-cycle press/release strobes.

Parameters:
NUM_SWITCHES, 4, number of switch inputs; must be 2 to 8.
DEBOUNCE_LIMIT, 250000, settle cycles (10 ms at 25 MHz); must be at least 2.
COUNT_WIDTH, 18, settle counter width; must satisfy 2^COUNT_WIDTH > DEBOUNCE_LIMIT-1.
OWNER_WIDTH, 2, must satisfy 2^OWNER_WIDTH >= NUM_SWITCHES.

Ports:
i_Clk  in  1  system clock (25 MHz).
i_Reset  in  1  synchronous, active-high reset.
i_Switch  in  NUM_SWITCHES  raw asynchronous switch levels.
o_Switch  out  NUM_SWITCHES  debounced committed levels.
o_Press  out  NUM_SWITCHES  one-cycle strobe when a bit commits 0->1.
o_Release  out  NUM_SWITCHES  one-cycle strobe when a bit commits 1->0.
o_Busy  out  1  high while the settle counter is granted (COUNT or COMMIT).
o_Owner  out  OWNER_WIDTH  index of the current or last granted switch.

Behaviour:
- Every output and internal register is updated on the i_Clk rising edge only.
- Reset, when i_Reset is high at an edge:
  - o_Switch, o_Press, o_Release = 0; o_Busy = 0; o_Owner = 0.
  - Round-robin pointer = 0; both synchronizer stages = 0; counter = 0; state = IDLE.
  - A reset in any state aborts any count in progress and emits no strobe.
- Synchronizer: 2 flops per bit, giving sync[i]. mismatch[i] = sync[i] XOR o_Switch[i].
- IDLE state:
  - If mismatch is nonzero: grant the first set bit searching upward from the pointer, wrapping modulo NUM_SWITCHES.
  - On grant: o_Owner = granted index, counter = 0, state = COUNT.
  - If mismatch is zero: stay in IDLE.
- COUNT state:
  - If mismatch[o_Owner] = 0 (bounce): abort, counter = 0, pointer = o_Owner+1 mod N, state = IDLE, no strobe.
  - Otherwise, if counter = DEBOUNCE_LIMIT-1: state = COMMIT.
  - Otherwise: counter increments by 1.
  - The counter never wraps.
- COMMIT state, which lasts one cycle:
  - If mismatch[o_Owner] = 0: abort as in COUNT.
  - Otherwise: o_Switch[o_Owner] = sync[o_Owner].
  - On a successful commit, raise exactly one strobe for one cycle, aligned with the o_Switch update: o_Press[o_Owner] if the new level is 1, else o_Release[o_Owner].
  - After COMMIT, pointer = o_Owner+1 mod N and state = IDLE.
- o_Busy = 1 exactly in COUNT and COMMIT.
- Latency: after i_Switch[i] changes and stays stable, with the counter free, the o_Switch[i] change and its strobe appear exactly DEBOUNCE_LIMIT+4 edges after the first edge that samples the new level. Breakdown: 2 synchronizer + 1 IDLE + DEBOUNCE_LIMIT COUNT + 1 COMMIT.
- Waiting switches:
  - A switch that changes while another switch owns the counter waits; its mismatch persists.
  - Worst-case wait is (NUM_SWITCHES-1)*(DEBOUNCE_LIMIT+2) cycles.
  - A mismatch that clears while waiting is never served and produces no strobe.
- Pulses shorter than DEBOUNCE_LIMIT never change o_Switch.
- Switches held high through reset are debounced after reset release and produce o_Press. This is intended.
- Strobes from different switches never occur in the same cycle; at most one strobe bit is set at a time.

Test Plan:
All scenarios use NUM_SWITCHES=4 and DEBOUNCE_LIMIT=8.
1. Reset, then drive i_Switch=4'b0001 and hold -> o_Switch[0]=1 and o_Press=4'b0001 for one cycle, exactly 12 edges later; o_Busy high for 9 cycles; o_Release stays 0.
2. Bounce: i_Switch[1] high for 5 cycles then low -> o_Switch stays 0, no strobe, o_Busy drops, pointer advances to 2.
3. Contention: i_Switch 0000 -> 1111 in one cycle -> commits occur in owner order 0,1,2,3, each 10 cycles apart; the four o_Press strobes never overlap.
4. Round-robin fairness: with pointer at 2, set bits 0 and 3 simultaneously -> owner 3 is served first, then 0.
5. Release: with o_Switch=0001, drop i_Switch[0] -> o_Release=0001 for one cycle after 12 edges; o_Switch=0000.
6. Assert i_Reset at counter value 5 during a count -> next cycle: all outputs 0, state IDLE, no strobe. If the input is still high after reset release, a full 12-edge debounce restarts.

Source files
------------

// File: rtl/debounce_scheduler.sv
// Time-shared switch debouncer: one settle counter is handed round-robin to
// whichever switch's synchronized level disagrees with its committed level.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | counter free; grant the next mismatching switch from r_ptr
// S_COUNT  | counter owned by r_owner; new level must hold DEBOUNCE_LIMIT clocks
// S_COMMIT | one cycle; commit the owner's level and emit press/release strobe
module debounce_scheduler #(
    parameter int NUM_SWITCHES   = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int COUNT_WIDTH    = 18,
    parameter int OWNER_WIDTH    = 2
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Press,
    output logic [NUM_SWITCHES-1:0] o_Release,
    output logic                    o_Busy,
    output logic [OWNER_WIDTH-1:0]  o_Owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LP_LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_LIMIT - 1);
    localparam logic [OWNER_WIDTH-1:0] LP_LAST_IDX   = OWNER_WIDTH'(NUM_SWITCHES - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [NUM_SWITCHES-1:0]   r_sync1;
    logic [NUM_SWITCHES-1:0]   r_sync2;
    logic [NUM_SWITCHES-1:0]   r_switch;
    logic [NUM_SWITCHES-1:0]   r_press;
    logic [NUM_SWITCHES-1:0]   r_release;
    logic [OWNER_WIDTH-1:0]    r_owner;
    logic [OWNER_WIDTH-1:0]    r_ptr;
    logic [COUNT_WIDTH-1:0]    r_count;

    logic [NUM_SWITCHES-1:0]   w_mismatch;
    logic [2*NUM_SWITCHES-1:0] w_rotated;
    logic                      w_grant_found;
    logic [OWNER_WIDTH-1:0]    w_grant_idx;
    logic                      w_owner_mm;
    logic [OWNER_WIDTH-1:0]    w_owner_inc;
    logic [OWNER_WIDTH-1:0]    w_owner_next;
    logic [OWNER_WIDTH-1:0]    w_ptr_next;
    logic [COUNT_WIDTH-1:0]    w_count_next;
    logic                      w_commit;

    assign w_mismatch  = r_sync2 ^ r_switch;
    assign w_owner_mm  = w_mismatch[r_owner];
    assign w_owner_inc = (r_owner == LP_LAST_IDX) ? '0 : r_owner + 1'b1;

    // Rotating the doubled mismatch vector by the pointer turns the wrapping
    // search into a plain lowest-set-bit search.
    assign w_rotated = {w_mismatch, w_mismatch} >> r_ptr;

    // Round-robin grant: lowest offset from the pointer wins (descending loop).
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = NUM_SWITCHES - 1; k >= 0; k--) begin
            if (w_rotated[k]) begin
                w_grant_found = 1'b1;
                if (int'(r_ptr) + k >= NUM_SWITCHES)
                    w_grant_idx = OWNER_WIDTH'(int'(r_ptr) + k - NUM_SWITCHES);
                else
                    w_grant_idx = OWNER_WIDTH'(int'(r_ptr) + k);
            end
        end
    end

    // Next-state logic for the settle-counter scheduler.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_count_next = r_count;
        w_commit     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_found) begin
                    w_owner_next = w_grant_idx;
                    w_count_next = '0;
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!w_owner_mm) begin
                    w_count_next = '0;
                    w_ptr_next   = w_owner_inc;
                    w_state_next = S_IDLE;
                end else if (r_count == LP_LAST_COUNT) begin
                    w_state_next = S_COMMIT;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            S_COMMIT: begin
                w_commit     = w_owner_mm;
                w_count_next = '0;
                w_ptr_next   = w_owner_inc;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Synchronizer, scheduler state and counter registers.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_Switch;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
            r_count <= w_count_next;
        end
    end

    // Committed levels and single-cycle strobes, updated together on commit.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_switch  <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_press   <= '0;
            r_release <= '0;
            if (w_commit) begin
                r_switch[r_owner] <= r_sync2[r_owner];
                if (r_sync2[r_owner])
                    r_press[r_owner] <= 1'b1;
                else
                    r_release[r_owner] <= 1'b1;
            end
        end
    end

    assign o_Switch  = r_switch;
    assign o_Press   = r_press;
    assign o_Release = r_release;
    assign o_Busy    = (r_state != S_IDLE);
    assign o_Owner   = r_owner;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed scenarios with literal timing plus
// randomized switch activity checked every cycle against a grant-age model.
module tb_debounce_scheduler;

    localparam int N  = 4;
    localparam int L  = 8;
    localparam int CW = 4;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          i_Reset;
    logic [N-1:0]  i_Switch;
    logic [N-1:0]  o_Switch;
    logic [N-1:0]  o_Press;
    logic [N-1:0]  o_Release;
    logic          o_Busy;
    logic [OW-1:0] o_Owner;

    int tests  = 0;
    int errors = 0;

    debounce_scheduler #(
        .NUM_SWITCHES  (N),
        .DEBOUNCE_LIMIT(L),
        .COUNT_WIDTH   (CW),
        .OWNER_WIDTH   (OW)
    ) dut (
        .i_Clk    (clk),
        .i_Reset  (i_Reset),
        .i_Switch (i_Switch),
        .o_Switch (o_Switch),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_Busy   (o_Busy),
        .o_Owner  (o_Owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. A grant lives for a fixed number of clocks (age 1..L+1);
    // the edge after age L+1 commits if the owner still disagrees.
    logic [N-1:0] m_s1, m_s2, m_sw, m_press, m_rel, m_mm;
    int           m_owner, m_ptr, m_age;
    bit           m_valid = 1'b0;
    bit           m_found;

    always @(posedge clk) begin
        if (i_Reset) begin
            m_s1 = '0; m_s2 = '0; m_sw = '0; m_press = '0; m_rel = '0;
            m_owner = 0; m_ptr = 0; m_age = 0; m_valid = 1'b1;
        end else begin
            m_mm    = m_s2 ^ m_sw;
            m_press = '0;
            m_rel   = '0;
            if (m_age == 0) begin
                m_found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!m_found && m_mm[(m_ptr + k) % N]) begin
                        m_found = 1'b1;
                        m_owner = (m_ptr + k) % N;
                        m_age   = 1;
                    end
                end
            end else if (!m_mm[m_owner]) begin
                m_age = 0;
                m_ptr = (m_owner + 1) % N;
            end else if (m_age == L + 1) begin
                m_sw[m_owner] = m_s2[m_owner];
                if (m_s2[m_owner]) m_press[m_owner] = 1'b1;
                else               m_rel[m_owner]   = 1'b1;
                m_age = 0;
                m_ptr = (m_owner + 1) % N;
            end else begin
                m_age++;
            end
            m_s2 = m_s1;
            m_s1 = i_Switch;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_switch",  32'(o_Switch),  32'(m_sw));
            check("cyc_press",   32'(o_Press),   32'(m_press));
            check("cyc_release", 32'(o_Release), 32'(m_rel));
            check("cyc_busy",    32'(o_Busy),    32'(m_age != 0));
            check("cyc_owner",   32'(o_Owner),   32'(m_owner));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        cyc(1);
        i_Reset = 1'b0;
    endtask

    // Counts negedges from the stimulus point until the wanted strobe shows.
    task automatic wait_strobe(input bit want_press, input logic [N-1:0] mask,
                               output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (o_Busy) busy_n++;
            if ((want_press ? o_Press : o_Release) == mask) break;
        end
    endtask

    int n, busy_n, strobes, hold;

    initial begin
        i_Reset  = 1'b1;
        i_Switch = '0;
        cyc(3);
        i_Reset = 1'b0;
        cyc(2);
        check("reset_switch", 32'(o_Switch), 32'h0);
        check("reset_busy",   32'(o_Busy),   32'h0);
        check("reset_owner",  32'(o_Owner),  32'h0);

        // 1: single press
        i_Switch = 4'b0001;
        wait_strobe(1'b1, 4'b0001, n, busy_n);
        check("t1_press_latency", 32'(n), 32'd12);
        check("t1_busy_cycles",   32'(busy_n), 32'd9);
        check("t1_switch",        32'(o_Switch), 32'h1);
        check("t1_no_release",    32'(o_Release), 32'h0);
        cyc(1);
        check("t1_press_one_cycle", 32'(o_Press), 32'h0);
        cyc(2);

        // 2: bounce on bit 1
        i_Switch = 4'b0011;
        cyc(5);
        i_Switch = 4'b0001;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_Press != 0 || o_Release != 0) strobes++;
        end
        check("t2_switch",  32'(o_Switch), 32'h1);
        check("t2_strobes", 32'(strobes), 32'd0);
        check("t2_busy",    32'(o_Busy), 32'h0);
        check("t2_owner",   32'(o_Owner), 32'd1);

        // 4: pointer at 2, bits 0 and 3 mismatch -> owner 3 first
        i_Switch = 4'b1000;
        wait_strobe(1'b1, 4'b1000, n, busy_n);
        check("t4_first_latency", 32'(n), 32'd12);
        check("t4_first_owner",   32'(o_Owner), 32'd3);
        wait_strobe(1'b0, 4'b0001, n, busy_n);
        check("t4_second_gap",   32'(n), 32'd10);
        check("t4_second_owner", 32'(o_Owner), 32'd0);
        check("t4_switch",       32'(o_Switch), 32'h8);
        cyc(2);

        // 5: release
        i_Switch = 4'b0001;
        wait_strobe(1'b0, 4'b1000, n, busy_n);
        check("t5_pre_release", 32'(n), 32'd12);
        wait_strobe(1'b1, 4'b0001, n, busy_n);
        check("t5_pre_press", 32'(n), 32'd10);
        cyc(2);
        i_Switch = 4'b0000;
        wait_strobe(1'b0, 4'b0001, n, busy_n);
        check("t5_release_latency", 32'(n), 32'd12);
        check("t5_switch",          32'(o_Switch), 32'h0);
        cyc(2);

        // 3: contention after reset
        do_reset();
        i_Switch = 4'b1111;
        wait_strobe(1'b1, 4'b0001, n, busy_n);
        check("t3_c0", 32'(n), 32'd12);
        wait_strobe(1'b1, 4'b0010, n, busy_n);
        check("t3_c1", 32'(n), 32'd10);
        wait_strobe(1'b1, 4'b0100, n, busy_n);
        check("t3_c2", 32'(n), 32'd10);
        wait_strobe(1'b1, 4'b1000, n, busy_n);
        check("t3_c3", 32'(n), 32'd10);
        check("t3_switch", 32'(o_Switch), 32'hF);
        cyc(2);

        // 6: reset in the middle of a count
        do_reset();
        i_Switch = 4'b0001;
        cyc(8);
        check("t6_busy_before", 32'(o_Busy), 32'h1);
        i_Reset = 1'b1;
        cyc(1);
        check("t6_switch", 32'(o_Switch), 32'h0);
        check("t6_busy",   32'(o_Busy), 32'h0);
        check("t6_strobe", 32'({o_Press, o_Release}), 32'h0);
        i_Reset = 1'b0;
        wait_strobe(1'b1, 4'b0001, n, busy_n);
        check("t6_restart_latency", 32'(n), 32'd12);
        cyc(2);

        // Randomized activity, including short pulses and occasional resets.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end
            i_Switch = N'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) hold = $urandom_range(1, 7);
            else                           hold = $urandom_range(8, 40);
            cyc(hold);
        end
        cyc(60);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
